// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side drives operands,
// adder side returns busy/done and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_dut.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, single registered carry.
// Result and carry-out update together with a one-cycle done pulse after WIDTH clocks.
module serial_adder_dut #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-2:0] rs_q, rs_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic [1:0]       fa;
    logic [WIDTH-1:0] shifted;

    // rs only keeps the upper WIDTH-1 result bits; the bit produced on the
    // final edge goes straight into sum.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        fa      = full_add(ra_q[0], rb_q[0], carry_q);
        shifted = {fa[0], rs_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = fa[1];
                rs_d    = shifted[WIDTH-1:1];
                ra_d    = {1'b0, ra_q[WIDTH-1:1]};
                rb_d    = {1'b0, rb_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = shifted;
                    cout_d  = fa[1];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_dut.sv
// Bench for serial_adder_dut: directed cases plus 200 random operations,
// with results and latency tracked by a scoreboard filled on accepted starts.
module tb_serial_adder_dut;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_dut #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH:0] res;
        int             cyc;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             run_len = 0;
    int             done_cnt = 0;
    logic           done_prev = 1'b0;
    logic [WIDTH:0] last_res = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Accepted start: record the reference result and the accept cycle.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && bus.start && !bus.busy) begin
            e.res = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
            e.cyc = cyc;
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run_len   = 0;
            done_prev = 1'b0;
            last_res  = {bus.cout, bus.sum};
        end else begin
            if (bus.busy) run_len++;
            if (bus.done) begin
                done_cnt++;
                check_val("done_width", {31'd0, done_prev}, 32'd0);
                check_val("done_expected", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_val("result", 32'({bus.cout, bus.sum}), 32'(e.res));
                    check_val("latency", 32'(cyc - e.cyc), WIDTH);
                end
                check_val("busy_len", 32'(run_len), WIDTH);
                run_len = 0;
            end else begin
                check_val("result_hold", 32'({bus.cout, bus.sum}), 32'(last_res));
            end
            last_res  = {bus.cout, bus.sum};
            done_prev = bus.done;
        end
    end

    // Called at a negedge; returns one negedge after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        bus.cin   = 1'($urandom);
    endtask

    // Returns at the negedge where done is high, or after a bounded wait.
    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic seen;
        int   d0;
        int   prev_cyc;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_done", {31'd0, bus.done}, 32'd0);
        check_val("rst_sum", 32'(bus.sum), 32'd0);
        check_val("rst_cout", {31'd0, bus.cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic addition
        start_op(8'h35, 8'h4A, 1'b0);
        check_val("t1_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(seen);
        check_val("t1_done_seen", {31'd0, seen}, 32'd1);
        check_val("t1_sum", 32'(bus.sum), 32'h7F);
        check_val("t1_cout", {31'd0, bus.cout}, 32'd0);

        // Carry out, then back-to-back start in the done cycle
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(seen);
        check_val("t2a_done_seen", {31'd0, seen}, 32'd1);
        check_val("t2a_sum", 32'(bus.sum), 32'h00);
        check_val("t2a_cout", {31'd0, bus.cout}, 32'd1);
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(seen);
        check_val("t2b_done_seen", {31'd0, seen}, 32'd1);
        check_val("t2b_sum", 32'(bus.sum), 32'hFF);
        check_val("t2b_cout", {31'd0, bus.cout}, 32'd1);

        // Start while busy is ignored
        start_op(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(seen);
        check_val("t3_done_seen", {31'd0, seen}, 32'd1);
        check_val("t3_sum", 32'(bus.sum), 32'h30);
        check_val("t3_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        check_val("t3_no_second_done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset mid-operation
        start_op(8'h80, 8'h80, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check_val("t4_busy", {31'd0, bus.busy}, 32'd0);
        check_val("t4_done", {31'd0, bus.done}, 32'd0);
        check_val("t4_sum", 32'(bus.sum), 32'd0);
        check_val("t4_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(seen);
        check_val("t4_done_seen", {31'd0, seen}, 32'd1);
        check_val("t4_sum_after", 32'(bus.sum), 32'h02);
        check_val("t4_cout_after", {31'd0, bus.cout}, 32'd0);

        // Start held high: one completion every WIDTH+1 clocks
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h0F;
        bus.b     = 8'h01;
        bus.cin   = 1'b1;
        prev_cyc  = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(seen);
            check_val("t5_done_seen", {31'd0, seen}, 32'd1);
            check_val("t5_sum", 32'(bus.sum), 32'h11);
            check_val("t5_cout", {31'd0, bus.cout}, 32'd0);
            if (k > 0) check_val("t5_spacing", 32'(cyc - prev_cyc), WIDTH + 1);
            prev_cyc = cyc;
            if (k == 3) bus.start = 1'b0;
            @(negedge clk);
        end

        // Random operations with random idle gaps (including none)
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_done(seen);
            check_val("t6_done_seen", {31'd0, seen}, 32'd1);
        end
        repeat (WIDTH + 4) @(negedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1);
    end

endmodule
